// File: rtl/code_sequencer_pkg.sv
// Shared definitions for the code sequencer: FSM encodings and default sizing
// matched to the 3-to-6 decoder it feeds.
package code_sequencer_pkg;
  localparam int W_DEF       = 3;
  localparam int N_CODES_DEF = 6;
  localparam int DWELL_DEF   = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
endpackage

// File: rtl/code_sequencer_step.sv
// Next-code logic: steps x up or down modulo N_CODES and flags a wrap.
module code_sequencer_step
  import code_sequencer_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int N_CODES = N_CODES_DEF
) (
  input  logic [W-1:0] x_i,
  input  logic         dir_i,
  output logic [W-1:0] nxt_o,
  output logic         wrap_o
);
  localparam logic [W-1:0] LAST = W'(N_CODES - 1);

  always_comb begin
    nxt_o  = x_i;
    wrap_o = 1'b0;
    if (dir_i) begin
      if (x_i == '0) begin
        nxt_o  = LAST;
        wrap_o = 1'b1;
      end else begin
        nxt_o = x_i - W'(1);
      end
    end else begin
      if (x_i == LAST) begin
        nxt_o  = '0;
        wrap_o = 1'b1;
      end else begin
        nxt_o = x_i + W'(1);
      end
    end
  end
endmodule

// File: rtl/code_sequencer.sv
// Generates decoder input codes over valid/ready, free-running or one-shot,
// with an optional idle gap after each accepted code.
module code_sequencer
  import code_sequencer_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int N_CODES = N_CODES_DEF,
  parameter int DWELL   = DWELL_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         oneshot,
  input  logic         dir,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         out_ready,
  output logic [W-1:0] x,
  output logic         x_valid,
  output logic         wrap,
  output logic         done,
  output logic         busy
);
  // Counter keeps at least one bit so DWELL=0 still elaborates cleanly.
  localparam int GW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((DWELL > 0) ? DWELL - 1 : 0);
  localparam logic [W-1:0]  LAST     = W'(N_CODES - 1);
  localparam logic [W:0]    NC_EXT   = (W+1)'(N_CODES);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          os_q, os_d;
  logic          vld_q, vld_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic [W-1:0]  step_nxt;
  logic          step_wrap;
  logic          at_end;

  code_sequencer_step #(.W(W), .N_CODES(N_CODES)) u_step (
    .x_i    (x_q),
    .dir_i  (dir),
    .nxt_o  (step_nxt),
    .wrap_o (step_wrap)
  );

  assign at_end = dir ? (x_q == '0) : (x_q == LAST);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    gap_d   = gap_q;
    os_d    = os_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      gap_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load && ({1'b0, load_val} < NC_EXT)) x_d = load_val;
          if (start) begin
            state_d = S_SHOW;
            os_d    = oneshot;
          end
        end
        S_SHOW: begin
          if (out_ready) begin
            if (os_q && at_end) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              x_d    = step_nxt;
              wrap_d = step_wrap;
              if (DWELL > 0) begin
                state_d = S_GAP;
                gap_d   = '0;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = S_SHOW;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    vld_d  = (state_d == S_SHOW);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      gap_q   <= '0;
      os_q    <= 1'b0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      gap_q   <= gap_d;
      os_q    <= os_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign x       = x_q;
  assign x_valid = vld_q;
  assign wrap    = wrap_q;
  assign done    = done_q;
  assign busy    = busy_q;
endmodule
